// File: rtl/pdm_audio_modulator_if.sv
// PCM sample handshake between the playback read path and the PDM modulator.
interface pdm_audio_modulator_if;
    logic [15:0] sample_data_i;
    logic        sample_valid_i;
    logic        sample_ready_o;

    modport master (
        output sample_data_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_data_i,
        input  sample_valid_i,
        output sample_ready_o
    );
endinterface

// File: rtl/pdm_audio_modulator.sv
// Playback PDM transmitter: one-deep sample holding register feeding a
// first-order sigma-delta modulator that emits one bit every CLK_DIV clocks
// and consumes one PCM sample every OSR bits.
module pdm_audio_modulator #(
    parameter int unsigned CLK_DIV = 50,
    parameter int unsigned OSR     = 64
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    pdm_audio_modulator_if.slave         pcm_if,
    output logic                         underflow_o,
    output logic                         busy_o,
    output logic                         pdm_o
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]   acc_q,     acc_d;
    logic [SAMPLE_W-1:0]   cur_q,     cur_d;
    logic [SAMPLE_W-1:0]   hold_q,    hold_d;
    logic                  full_q,    full_d;
    logic                  ready_q,   ready_d;
    logic                  pdm_q,     pdm_d;
    logic                  underflow_q, underflow_d;
    logic                  busy_q,    busy_d;

    logic                  strobe_c;
    logic                  boundary_c;
    logic                  accept_c;
    logic                  consume_c;
    logic [SAMPLE_W-1:0]   offset_c;
    logic [SAMPLE_W:0]     sum_c;

    // Bit strobe, sample boundary, handshake and modulator adder.
    always_comb begin
        strobe_c   = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
        boundary_c = strobe_c && (bit_cnt_q == BIT_LAST);
        accept_c   = pcm_if.sample_valid_i && ready_q;
        offset_c   = {~cur_q[SAMPLE_W-1], cur_q[SAMPLE_W-2:0]};
        sum_c      = {1'b0, acc_q} + {1'b0, offset_c};
    end

    // Next-state and datapath update for the run/drain/idle controller.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        cur_d       = cur_q;
        pdm_d       = pdm_q;
        underflow_d = 1'b0;
        consume_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pdm_d     = 1'b0;
                acc_d     = '0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable_i) begin
                    state_d   = ST_RUN;
                    consume_c = full_q;
                    cur_d     = full_q ? hold_q : '0;
                end
            end

            ST_RUN, ST_DRAIN: begin
                state_d = enable_i ? ST_RUN : ST_DRAIN;
                if (strobe_c) begin
                    div_cnt_d = '0;
                    pdm_d     = sum_c[SAMPLE_W];
                    acc_d     = sum_c[SAMPLE_W-1:0];
                    if (boundary_c) begin
                        bit_cnt_d = '0;
                        if ((state_q == ST_DRAIN) && !enable_i) begin
                            // Stop cleanly: the held sample stays for the next run.
                            state_d = ST_IDLE;
                            pdm_d   = 1'b0;
                            acc_d   = '0;
                        end else if (full_q) begin
                            cur_d     = hold_q;
                            consume_c = 1'b1;
                        end else begin
                            cur_d       = '0;
                            underflow_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: consume and accept are exclusive because ready is low while full.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (consume_c) begin
            full_d = 1'b0;
        end
        if (accept_c) begin
            hold_d = pcm_if.sample_data_i;
            full_d = 1'b1;
        end
        // Ready drops together with the accept and returns one cycle after a consume.
        ready_d = !full_q && !accept_c;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            cur_q       <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            ready_q     <= 1'b1;
            pdm_q       <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            cur_q       <= cur_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            ready_q     <= ready_d;
            pdm_q       <= pdm_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
        end
    end

    assign pcm_if.sample_ready_o = ready_q;
    assign underflow_o           = underflow_q;
    assign busy_o                = busy_q;
    assign pdm_o                 = pdm_q;

endmodule

// File: tb/tb_pdm_audio_modulator.sv
// Bench for pdm_audio_modulator: directed scenarios plus randomized traffic,
// every cycle compared against a sample-queue reference model.
module tb_pdm_audio_modulator;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned OSR     = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic underflow, busy, pdm;

    pdm_audio_modulator_if pcm_if ();

    pdm_audio_modulator #(.CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .enable_i    (en),
        .pcm_if      (pcm_if),
        .underflow_o (underflow),
        .busy_o      (busy),
        .pdm_o       (pdm)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t_run = 0;

    // Reference model state
    int          m_state;
    int          m_div;
    int          m_bit;
    logic [15:0] m_acc;
    logic [15:0] m_cur;
    logic [15:0] m_hold[$];
    logic        m_pdm, m_und, m_busy, m_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_div   = 0;
        m_bit   = 0;
        m_acc   = '0;
        m_cur   = '0;
        m_hold.delete();
        m_pdm   = 1'b0;
        m_und   = 1'b0;
        m_busy  = 1'b0;
        m_ready = 1'b1;
    endtask

    // One clock of the model, using the inputs present at the edge.
    task automatic model_step();
        logic        take;
        logic        nready;
        logic [16:0] sum;
        int          nstate;
        if (!rst_n) begin
            model_reset();
            return;
        end
        take   = pcm_if.sample_valid_i && m_ready;
        nready = (m_hold.size() == 0) && !take;
        m_und  = 1'b0;
        if (m_state == M_IDLE) begin
            m_pdm = 1'b0;
            m_acc = '0;
            m_div = 0;
            m_bit = 0;
            if (en) begin
                m_state = M_RUN;
                if (m_hold.size() != 0) m_cur = m_hold.pop_front();
                else                    m_cur = '0;
            end
        end else begin
            nstate = en ? M_RUN : M_DRAIN;
            if (m_div == CLK_DIV - 1) begin
                m_div = 0;
                // Offset-binary conversion is a flip of the sign bit.
                sum   = {1'b0, m_acc} + {1'b0, m_cur ^ 16'h8000};
                m_pdm = sum[16];
                m_acc = sum[15:0];
                if (m_bit == OSR - 1) begin
                    m_bit = 0;
                    if (m_state == M_DRAIN && !en) begin
                        nstate = M_IDLE;
                        m_pdm  = 1'b0;
                        m_acc  = '0;
                    end else if (m_hold.size() != 0) begin
                        m_cur = m_hold.pop_front();
                    end else begin
                        m_cur = '0;
                        m_und = 1'b1;
                    end
                end else begin
                    m_bit++;
                end
            end else begin
                m_div++;
            end
            m_state = nstate;
        end
        if (take) m_hold.push_back(pcm_if.sample_data_i);
        m_ready = nready;
        m_busy  = (m_state != M_IDLE);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("pdm",       32'(pdm),                   32'(m_pdm));
        check("ready",     32'(pcm_if.sample_ready_o), 32'(m_ready));
        check("underflow", 32'(underflow),             32'(m_und));
        check("busy",      32'(busy),                  32'(m_busy));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pdm"},   32'(pdm),                   32'd0);
        check({tag, "_busy"},  32'(busy),                  32'd0);
        check({tag, "_ready"}, 32'(pcm_if.sample_ready_o), 32'd1);
        check({tag, "_unf"},   32'(underflow),             32'd0);
    endtask

    // Hold reset with inputs toggling, then release with inputs quiet.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom);
            pcm_if.sample_valid_i = 1'($urandom);
            pcm_if.sample_data_i  = 16'($urandom);
            step();
            check_reset_vals("rst_hold");
        end
        en = 1'b0;
        pcm_if.sample_valid_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    // Push one sample while idle, then enable; t_run marks the RUN entry edge.
    task automatic load_and_start(input logic [15:0] s);
        pcm_if.sample_data_i  = s;
        pcm_if.sample_valid_i = 1'b1;
        step();
        pcm_if.sample_valid_i = 1'b0;
        en = 1'b1;
        step();
        t_run = cyc;
    endtask

    initial begin
        int k;
        int nacc;
        int k_c;
        logic take;
        model_reset();
        pcm_if.sample_data_i  = '0;
        pcm_if.sample_valid_i = 1'b0;

        // Reset values with inputs toggling.
        do_reset();

        // Silence sample: alternating bits, ready recovers, single underflow at cycle 32.
        pcm_if.sample_data_i  = 16'h0000;
        pcm_if.sample_valid_i = 1'b1;
        step();
        check("t2_ready_after_push", 32'(pcm_if.sample_ready_o), 32'd0);
        pcm_if.sample_valid_i = 1'b0;
        en = 1'b1;
        step();
        t_run = cyc;
        check("t2_ready_k0", 32'(pcm_if.sample_ready_o), 32'd0);
        for (int i = 1; i <= 40; i++) begin
            step();
            k = cyc - t_run;
            if (k == 1) check("t2_ready_k1", 32'(pcm_if.sample_ready_o), 32'd1);
            if (k % 4 == 0) check("t2_bit", 32'(pdm), 32'((k / 4 - 1) % 2));
            if (k >= 31 && k <= 33) check("t4_underflow", 32'(underflow), 32'(k == 32));
        end

        // Full scale positive then full scale negative.
        do_reset();
        load_and_start(16'h7FFF);
        pcm_if.sample_data_i  = 16'h8000;
        pcm_if.sample_valid_i = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            take = pcm_if.sample_valid_i && pcm_if.sample_ready_o;
            step();
            if (take) pcm_if.sample_valid_i = 1'b0;
            k = cyc - t_run;
            if (k % 4 == 0 && k <= 32) check("t3_p1_bit", 32'(pdm), (k == 4) ? 32'd0 : 32'd1);
            if (k % 4 == 0 && k > 32)  check("t3_p2_bit", 32'(pdm), 32'd0);
            if (k == 32) check("t3_no_underflow", 32'(underflow), 32'd0);
            if (k == 64) check("t3_end_underflow", 32'(underflow), 32'd1);
        end

        // Backpressure: B waits in holding, C only after B is consumed.
        do_reset();
        load_and_start(16'($urandom));
        pcm_if.sample_data_i  = 16'($urandom);
        pcm_if.sample_valid_i = 1'b1;
        nacc = 0;
        k_c  = -1;
        for (int i = 1; i <= 66; i++) begin
            take = pcm_if.sample_valid_i && pcm_if.sample_ready_o;
            step();
            k = cyc - t_run;
            if (take) begin
                nacc++;
                if (nacc == 1) pcm_if.sample_data_i = 16'($urandom);
                if (nacc == 2) begin
                    k_c = k;
                    pcm_if.sample_valid_i = 1'b0;
                end
            end
            if (k == 32) check("t5_ready_k32", 32'(pcm_if.sample_ready_o), 32'd0);
            if (k == 33) check("t5_ready_k33", 32'(pcm_if.sample_ready_o), 32'd1);
            if (k == 64) check("t5_no_underflow", 32'(underflow), 32'd0);
        end
        check("t5_accepts", 32'(nacc), 32'd2);
        check("t5_c_accept_cycle", 32'(k_c), 32'd34);

        // Drop enable after bit 3: period completes, then idle.
        do_reset();
        load_and_start(16'($urandom));
        for (int i = 1; i <= 40; i++) begin
            step();
            k = cyc - t_run;
            if (k == 16) en = 1'b0;
            if (k == 24 || k == 31) check("t6_busy_drain", 32'(busy), 32'd1);
            if (k == 32 || k == 40) begin
                check("t6_busy_idle", 32'(busy), 32'd0);
                check("t6_pdm_idle",  32'(pdm),  32'd0);
            end
        end

        // Same again, but asynchronous reset mid-period.
        en = 1'b1;
        step();
        for (int i = 1; i <= 18; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async_rst");
        model_reset();
        en = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Randomized traffic with random enable toggling.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            pcm_if.sample_valid_i = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       pcm_if.sample_data_i = 16'h7FFF;
                1:       pcm_if.sample_data_i = 16'h8000;
                2:       pcm_if.sample_data_i = 16'h0000;
                default: pcm_if.sample_data_i = 16'($urandom);
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
